// File: rtl/mdu_pkg.sv
// Shared definitions for the MUL/DIV instruction sequencer: state encoding,
// ALU opcodes and IR field positions.
package mdu_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_DONE = 4'd8,
    S_ERR  = 4'd9
  } state_e;

  localparam logic [4:0] ALU_MUL = 5'b01001;
  localparam logic [4:0] ALU_DIV = 5'b01010;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;

  function automatic logic is_mdu_op(input logic [4:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/mdu_sequencer_reg_decoder.sv
// 4-bit register index plus enable to a 16-bit one-hot register drive enable.
module reg_decoder_4to16 (
  input  logic [3:0]  idx_i,
  input  logic        en_i,
  output logic [15:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Moore sequencer for one instruction fetch followed by a MUL/DIV execute;
// every strobe is decoded from the registered state (and IR in T3).
module mdu_sequencer
  import mdu_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [15:0] Rout,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        LOin,
  output logic        HIin,
  output logic [4:0]  ALU_Control
);

  state_e     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic [3:0] ra_q, ra_d;
  logic [3:0] rb_q, rb_d;

  logic [4:0] ir_op;
  logic [3:0] ir_ra;
  logic [3:0] ir_rb;
  logic       ir_legal;

  assign ir_op    = ir[OP_MSB:OP_LSB];
  assign ir_ra    = ir[RA_MSB:RA_LSB];
  assign ir_rb    = ir[RB_MSB:RB_LSB];
  assign ir_legal = is_mdu_op(ir_op);

  // Low IR bits carry no meaning here; ra is latched for observability only.
  logic unused_bits;
  assign unused_bits = ^{ir[RB_LSB-1:0], ra_q};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (ir_legal) begin
          state_d = S_T4;
          op_d    = ir_op;
          ra_d    = ir_ra;
          rb_d    = ir_rb;
        end else begin
          state_d = S_ERR;
        end
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = S_T6;
      S_T6:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
    end
  end

  // T3 selects ra straight from IR (latching happens at the end of T3);
  // T4 uses the latched rb so IR may change after the fetch completes.
  logic [3:0] rsel;
  logic       rsel_en;

  assign rsel    = (state_q == S_T3) ? ir_ra : rb_q;
  assign rsel_en = ((state_q == S_T3) && ir_legal) || (state_q == S_T4);

  reg_decoder_4to16 u_rdec (
    .idx_i    (rsel),
    .en_i     (rsel_en),
    .onehot_o (Rout)
  );

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = 1'b0;
    illegal     = 1'b0;
    PCout       = 1'b0;
    MARin       = 1'b0;
    IncPC       = 1'b0;
    Zin         = 1'b0;
    Zlowout     = 1'b0;
    Zhighout    = 1'b0;
    PCin        = 1'b0;
    Read        = 1'b0;
    MDRin       = 1'b0;
    MDRout      = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    LOin        = 1'b0;
    HIin        = 1'b0;
    ALU_Control = '0;
    case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      // Held for the whole memory stall; rewriting PC from Z is harmless.
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: Yin = ir_legal;
      S_T4: begin
        Zin         = 1'b1;
        ALU_Control = op_q;
      end
      S_T5: begin
        Zlowout = 1'b1;
        LOin    = 1'b1;
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      S_DONE: done    = 1'b1;
      S_ERR:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboarded bench for mdu_sequencer: directed instructions push expected
// done/illegal pulses, a monitor pops them and checks per-cycle invariants.
module tb_mdu_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
  logic        busy, done, illegal;
  logic [15:0] Rout;
  logic        PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read;
  logic        MDRin, MDRout, IRin, Yin, LOin, HIin;
  logic [4:0]  ALU_Control;

  mdu_sequencer dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .mem_ready   (mem_ready),
    .ir          (ir),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .Rout        (Rout),
    .PCout       (PCout),
    .MARin       (MARin),
    .IncPC       (IncPC),
    .Zin         (Zin),
    .Zlowout     (Zlowout),
    .Zhighout    (Zhighout),
    .PCin        (PCin),
    .Read        (Read),
    .MDRin       (MDRin),
    .MDRout      (MDRout),
    .IRin        (IRin),
    .Yin         (Yin),
    .LOin        (LOin),
    .HIin        (HIin),
    .ALU_Control (ALU_Control)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit is_done;
    int cyc;
  } exp_t;
  exp_t q[$];

  logic [13:0] strb;
  assign strb = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read,
                 MDRin, MDRout, IRin, Yin, LOin, HIin};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_cyc(input string tag, input logic [13:0] v, input logic [15:0] r,
                           input logic [4:0] a, input logic b);
    chk({tag, "_strobes"}, 32'(strb), 32'(v));
    chk({tag, "_rout"},    32'(Rout), 32'(r));
    chk({tag, "_alu"},     32'(ALU_Control), 32'(a));
    chk({tag, "_busy"},    32'(busy), 32'(b));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: pulse scoreboard plus per-cycle Rout/ALU_Control invariants.
  always @(negedge clock) begin
    exp_t e;
    chk("rout_onehot_or_zero", 32'((Rout & (Rout - 16'd1)) == 16'd0), 32'd1);
    if (!(Zin && !PCout)) chk("alu_zero_outside_T4", 32'(ALU_Control), 32'd0);
    if (done || illegal) begin
      chk("pulse_was_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pulse_kind", 32'({done, illegal}), e.is_done ? 32'd2 : 32'd1);
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic run_op(input logic [31:0] irv, input int stall, input string tag);
    logic [4:0] op;
    logic [3:0] ra, rb;
    logic       legal;
    int         c0;
    exp_t       e;
    op    = irv[31:27];
    ra    = irv[26:23];
    rb    = irv[22:19];
    legal = (op == 5'b01001) || (op == 5'b01010);
    ir        = irv;
    mem_ready = (stall == 0);
    start     = 1'b1;
    c0        = cyc;
    e.is_done = legal;
    e.cyc     = c0 + stall + (legal ? 8 : 5);
    q.push_back(e);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    step();
    start = 1'b0;
    check_cyc({tag, "_T0"}, 14'h3C00, 16'h0000, 5'd0, 1'b1);
    step();
    for (int i = 0; i <= stall; i++) begin
      check_cyc({tag, "_T1"}, 14'h02E0, 16'h0000, 5'd0, 1'b1);
      if (i == stall) mem_ready = 1'b1;
      step();
    end
    check_cyc({tag, "_T2"}, 14'h0018, 16'h0000, 5'd0, 1'b1);
    step();
    if (legal) begin
      check_cyc({tag, "_T3"}, 14'h0004, 16'h0001 << ra, 5'd0, 1'b1);
      step();
      check_cyc({tag, "_T4"}, 14'h0400, 16'h0001 << rb, op, 1'b1);
      step();
      check_cyc({tag, "_T5"}, 14'h0202, 16'h0000, 5'd0, 1'b1);
      step();
      check_cyc({tag, "_T6"}, 14'h0101, 16'h0000, 5'd0, 1'b1);
      step();
      check_cyc({tag, "_DONE"}, 14'h0000, 16'h0000, 5'd0, 1'b1);
      step();
    end else begin
      check_cyc({tag, "_T3"}, 14'h0000, 16'h0000, 5'd0, 1'b1);
      step();
      check_cyc({tag, "_ERR"}, 14'h0000, 16'h0000, 5'd0, 1'b1);
      step();
    end
    check_cyc({tag, "_IDLE"}, 14'h0000, 16'h0000, 5'd0, 1'b0);
    chk({tag, "_scoreboard_empty"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   c0;
    clear     = 1'b0;
    start     = 1'b0;
    mem_ready = 1'b0;
    ir        = '0;
    #12;
    check_cyc("reset", 14'h0000, 16'h0000, 5'd0, 1'b0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);
    step();
    clear = 1'b1;

    run_op(32'h52B00000, 0, "div");
    run_op(32'h4A200000, 3, "mul_stall");
    run_op(32'h18000000, 0, "illegal");
    run_op(32'h4B180000, 1, "mul_r6_r3");

    // Abort in T4 with an asynchronous clear.
    ir        = 32'h52B00000;
    mem_ready = 1'b1;
    start     = 1'b1;
    c0        = cyc;
    e.is_done = 1'b1;
    e.cyc     = c0 + 8;
    q.push_back(e);
    step();
    start = 1'b0;
    repeat (4) step();
    check_cyc("rst_T4", 14'h0400, 16'h0040, 5'b01010, 1'b1);
    #2 clear = 1'b0;
    #1;
    check_cyc("rst_async", 14'h0000, 16'h0000, 5'd0, 1'b0);
    chk("rst_async_done", 32'(done), 32'd0);
    q.delete();
    step();
    check_cyc("rst_held", 14'h0000, 16'h0000, 5'd0, 1'b0);
    clear = 1'b1;
    run_op(32'h52B00000, 0, "post_reset");

    // Start held high: two sequences, one IDLE cycle between them.
    step();
    ir        = 32'h52B00000;
    mem_ready = 1'b1;
    start     = 1'b1;
    c0        = cyc;
    e.is_done = 1'b1;
    e.cyc     = c0 + 8;
    q.push_back(e);
    e.cyc     = c0 + 17;
    q.push_back(e);
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 18) start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'(((k >= 1) && (k <= 8)) || ((k >= 10) && (k <= 17))));
      if (k == 10) check_cyc("b2b_second_T0", 14'h3C00, 16'h0000, 5'd0, 1'b1);
    end
    chk("b2b_scoreboard_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
